// File: rtl/uart_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_prog_loader
// Purpose  : Serial program loader. Receives 8N1 UART bytes and turns them
//            into 16-bit words (high byte first) written to consecutive
//            program-RAM addresses starting at 0. The first byte of a
//            session is the word count N (0 encodes 256). The CPU core is
//            held for the whole session.
// Ports    : clk      - system clock, rising edge
//            rst      - synchronous active-low reset
//            rx       - asynchronous UART line, idle high
//            addrWr   - RAM write address (8 bits)
//            dataWr   - RAM write data (16 bits)
//            wrEn     - one-cycle RAM write strobe
//            cpuHold  - high while a load session is active
//            loadDone - one-cycle pulse when the last word is written
//            frameErr - sticky framing-error flag, cleared only by reset
// Revision : 1.0  initial release
// ============================================================================
module uart_prog_loader #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [7:0]  addrWr,
    output logic [15:0] dataWr,
    output logic        wrEn,
    output logic        cpuHold,
    output logic        loadDone,
    output logic        frameErr
);

    localparam int BIT_CYC = CLK_FREQ / BAUD;
    localparam int CNT_W   = $clog2(BIT_CYC);

    localparam logic [CNT_W-1:0] c_bitLast  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] c_halfLast = CNT_W'(BIT_CYC / 2 - 1);
    localparam logic [CNT_W-1:0] c_cntOne   = CNT_W'(1);

    // Byte receiver states
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // Session states
    localparam logic [1:0] S_WAIT_CNT = 2'd0;
    localparam logic [1:0] S_HI       = 2'd1;
    localparam logic [1:0] S_LO       = 2'd2;
    localparam logic [1:0] S_WR       = 2'd3;

    // ------------------------------------------------------------------
    // Input synchronizer; r_rxPrev is one more stage used only for the
    // falling-edge detect that starts a frame.
    // ------------------------------------------------------------------
    logic r_rxMeta;
    logic r_rxS;
    logic r_rxPrev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rxMeta <= 1'b1;
            r_rxS    <= 1'b1;
            r_rxPrev <= 1'b1;
        end else begin
            r_rxMeta <= rx;
            r_rxS    <= r_rxMeta;
            r_rxPrev <= r_rxS;
        end
    end

    // ------------------------------------------------------------------
    // Byte receiver
    // ------------------------------------------------------------------
    logic [1:0]       r_rxState;
    logic [1:0]       w_rxNext;
    logic [CNT_W-1:0] r_cycCnt;
    logic [2:0]       r_bitCnt;
    logic [7:0]       r_shift;
    logic             r_byteValid;
    logic             r_frameErrEvt;
    logic             w_bitTick;
    logic             w_halfTick;

    always_ff @(posedge clk) begin
        if (!rst) r_rxState <= RX_IDLE;
        else      r_rxState <= w_rxNext;
    end

    always_comb begin
        w_rxNext   = r_rxState;
        w_bitTick  = (r_cycCnt == c_bitLast);
        w_halfTick = (r_cycCnt == c_halfLast);
        case (r_rxState)
            RX_IDLE:  if (r_rxPrev && !r_rxS) w_rxNext = RX_START;
            // Line back high at mid start bit is a glitch, not a frame.
            RX_START: if (w_halfTick) w_rxNext = r_rxS ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_bitTick && (r_bitCnt == 3'd7)) w_rxNext = RX_STOP;
            RX_STOP:  if (w_bitTick) w_rxNext = RX_IDLE;
            default:  w_rxNext = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cycCnt      <= '0;
            r_bitCnt      <= 3'd0;
            r_shift       <= 8'd0;
            r_byteValid   <= 1'b0;
            r_frameErrEvt <= 1'b0;
        end else begin
            r_byteValid   <= 1'b0;
            r_frameErrEvt <= 1'b0;
            case (r_rxState)
                RX_IDLE: begin
                    r_cycCnt <= '0;
                    r_bitCnt <= 3'd0;
                end
                RX_START: begin
                    r_cycCnt <= w_halfTick ? '0 : r_cycCnt + c_cntOne;
                end
                RX_DATA: begin
                    if (w_bitTick) begin
                        r_cycCnt <= '0;
                        r_shift  <= {r_rxS, r_shift[7:1]};  // LSB arrives first
                        r_bitCnt <= r_bitCnt + 3'd1;
                    end else begin
                        r_cycCnt <= r_cycCnt + c_cntOne;
                    end
                end
                RX_STOP: begin
                    if (w_bitTick) begin
                        r_cycCnt <= '0;
                        if (r_rxS) r_byteValid   <= 1'b1;
                        else       r_frameErrEvt <= 1'b1;
                    end else begin
                        r_cycCnt <= r_cycCnt + c_cntOne;
                    end
                end
                default: r_cycCnt <= '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Session control. r_shift is stable while r_byteValid is high since
    // the receiver is back in IDLE by then.
    // ------------------------------------------------------------------
    logic [1:0]  r_sesState;
    logic [1:0]  w_sesNext;
    logic [8:0]  r_remaining;
    logic [7:0]  r_addrWr;
    logic [15:0] r_dataWr;
    logic        r_wrEn;
    logic        r_cpuHold;
    logic        r_loadDone;
    logic        r_frameErr;

    always_ff @(posedge clk) begin
        if (!rst) r_sesState <= S_WAIT_CNT;
        else      r_sesState <= w_sesNext;
    end

    always_comb begin
        w_sesNext = r_sesState;
        if (r_frameErrEvt) begin
            w_sesNext = S_WAIT_CNT;
        end else begin
            case (r_sesState)
                S_WAIT_CNT: if (r_byteValid) w_sesNext = S_HI;
                S_HI:       if (r_byteValid) w_sesNext = S_LO;
                S_LO:       if (r_byteValid) w_sesNext = S_WR;
                S_WR:       w_sesNext = (r_remaining == 9'd1) ? S_WAIT_CNT : S_HI;
                default:    w_sesNext = S_WAIT_CNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_remaining <= 9'd0;
            r_addrWr    <= 8'd0;
            r_dataWr    <= 16'd0;
            r_wrEn      <= 1'b0;
            r_cpuHold   <= 1'b0;
            r_loadDone  <= 1'b0;
            r_frameErr  <= 1'b0;
        end else begin
            r_wrEn     <= 1'b0;
            r_loadDone <= 1'b0;
            if (r_frameErrEvt) begin
                // Abort: words already written stay, address is kept.
                r_frameErr <= 1'b1;
                r_cpuHold  <= 1'b0;
            end else begin
                case (r_sesState)
                    S_WAIT_CNT: begin
                        if (r_byteValid) begin
                            r_cpuHold   <= 1'b1;
                            r_addrWr    <= 8'd0;
                            r_remaining <= (r_shift == 8'd0) ? 9'd256 : {1'b0, r_shift};
                        end
                    end
                    S_HI: begin
                        if (r_byteValid) r_dataWr[15:8] <= r_shift;
                    end
                    S_LO: begin
                        if (r_byteValid) begin
                            r_dataWr[7:0] <= r_shift;
                            r_wrEn        <= 1'b1;
                        end
                    end
                    S_WR: begin
                        // Address advances only after the strobe, so a
                        // 256-word load wraps to 0 after its final write.
                        r_addrWr    <= r_addrWr + 8'd1;
                        r_remaining <= r_remaining - 9'd1;
                        if (r_remaining == 9'd1) begin
                            r_loadDone <= 1'b1;
                            r_cpuHold  <= 1'b0;
                        end
                    end
                    default: r_cpuHold <= 1'b0;
                endcase
            end
        end
    end

    assign addrWr   = r_addrWr;
    assign dataWr   = r_dataWr;
    assign wrEn     = r_wrEn;
    assign cpuHold  = r_cpuHold;
    assign loadDone = r_loadDone;
    assign frameErr = r_frameErr;

endmodule
`default_nettype wire

// File: tb/tb_uart_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_prog_loader
// Purpose  : Self-checking bench for uart_prog_loader. Stimulus pushes the
//            expected RAM writes into a queue; a monitor pops and compares
//            on every wrEn and checks loadDone/cpuHold alignment.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_prog_loader;

    localparam int CLK_FREQ = 1600;
    localparam int BAUD     = 100;
    localparam int BIT_CYC  = CLK_FREQ / BAUD;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx  = 1'b1;
    logic [7:0]  addrWr;
    logic [15:0] dataWr;
    logic        wrEn;
    logic        cpuHold;
    logic        loadDone;
    logic        frameErr;

    uart_prog_loader #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .addrWr   (addrWr),
        .dataWr   (dataWr),
        .wrEn     (wrEn),
        .cpuHold  (cpuHold),
        .loadDone (loadDone),
        .frameErr (frameErr)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          expDone  = 0;
    int          doneCnt  = 0;
    logic [23:0] expQ[$];
    logic [23:0] expWr;
    logic        prevHold = 1'b0;
    logic        prevWr   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            if (wrEn) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: actual addr=%0h data=%0h expected no write",
                             addrWr, dataWr);
                end else begin
                    expWr = expQ.pop_front();
                    chk("wr_addr", 32'(addrWr), 32'(expWr[23:16]));
                    chk("wr_data", 32'(dataWr), 32'(expWr[15:0]));
                end
                chk("hold_during_wr", 32'(cpuHold), 32'd1);
            end
            if (loadDone) begin
                doneCnt++;
                chk("done_after_wr", 32'(prevWr), 32'd1);
                chk("done_hold_fall", 32'({prevHold, cpuHold}), 32'd2);
            end
        end
        prevHold = cpuHold;
        prevWr   = wrEn;
    end

    // One 8N1 frame; stopBit=0 forces a framing error.
    task automatic sendByte(input logic [7:0] b, input logic stopBit);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        rx = stopBit;
        repeat (BIT_CYC) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic phaseEnd(input string name);
        repeat (30) @(negedge clk);
        chk({name, "_writes_left"}, 32'(expQ.size()), 32'd0);
        chk({name, "_done_count"}, 32'(doneCnt), 32'(expDone));
    endtask

    initial begin
        // Reset
        rst = 1'b0;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_addr", 32'(addrWr), 32'd0);
        chk("rst_data", 32'(dataWr), 32'd0);
        chk("rst_wren", 32'(wrEn), 32'd0);
        chk("rst_hold", 32'(cpuHold), 32'd0);
        chk("rst_done", 32'(loadDone), 32'd0);
        chk("rst_ferr", 32'(frameErr), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Two-word session
        expQ.push_back({8'h00, 16'hA53C});
        expQ.push_back({8'h01, 16'h1234});
        expDone++;
        sendByte(8'h02, 1'b1);
        chk("s1_hold_up", 32'(cpuHold), 32'd1);
        sendByte(8'hA5, 1'b1);
        sendByte(8'h3C, 1'b1);
        sendByte(8'h12, 1'b1);
        chk("s1_hold_mid", 32'(cpuHold), 32'd1);
        sendByte(8'h34, 1'b1);
        phaseEnd("s1");
        chk("s1_hold_end", 32'(cpuHold), 32'd0);
        chk("s1_addr_end", 32'(addrWr), 32'd2);

        // Framing error aborts, then a fresh session still works
        sendByte(8'h01, 1'b1);
        chk("fe_hold_up", 32'(cpuHold), 32'd1);
        sendByte(8'hFF, 1'b0);
        repeat (3) @(negedge clk);
        chk("fe_flag", 32'(frameErr), 32'd1);
        chk("fe_hold_drop", 32'(cpuHold), 32'd0);
        expQ.push_back({8'h00, 16'hBEEF});
        expDone++;
        sendByte(8'h01, 1'b1);
        sendByte(8'hBE, 1'b1);
        sendByte(8'hEF, 1'b1);
        phaseEnd("fe");
        chk("fe_flag_sticky", 32'(frameErr), 32'd1);
        chk("fe_addr_end", 32'(addrWr), 32'd1);

        // Short glitch on the idle line
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("gl_addr", 32'(addrWr), 32'd1);
        chk("gl_data", 32'(dataWr), 32'hBEEF);
        chk("gl_hold", 32'(cpuHold), 32'd0);
        chk("gl_ferr", 32'(frameErr), 32'd1);
        chk("gl_done_count", 32'(doneCnt), 32'(expDone));

        // Count 0 means 256 words
        for (int i = 0; i < 256; i++) begin
            expQ.push_back({8'(i), 8'(i), ~8'(i)});
        end
        expDone++;
        sendByte(8'h00, 1'b1);
        for (int i = 0; i < 256; i++) begin
            sendByte(8'(i), 1'b1);
            sendByte(~8'(i), 1'b1);
        end
        phaseEnd("n256");
        chk("n256_addr_wrap", 32'(addrWr), 32'd0);
        chk("n256_hold_end", 32'(cpuHold), 32'd0);

        // Reset in the middle of a session
        sendByte(8'h03, 1'b1);
        sendByte(8'h11, 1'b1);
        chk("mr_hold_up", 32'(cpuHold), 32'd1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mr_hold", 32'(cpuHold), 32'd0);
        chk("mr_addr", 32'(addrWr), 32'd0);
        chk("mr_data", 32'(dataWr), 32'd0);
        chk("mr_ferr", 32'(frameErr), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        expQ.push_back({8'h00, 16'hCAFE});
        expDone++;
        sendByte(8'h01, 1'b1);
        sendByte(8'hCA, 1'b1);
        sendByte(8'hFE, 1'b1);
        phaseEnd("mr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Serial program loader feeding the 1R1W program RAM write port (addrWr/dataWr/wrEn); alternative source to the switch/enter programming path.
- Receives 8N1 UART bytes and assembles 16-bit instruction words, high byte first.
- Writes words to consecutive RAM addresses from 0.
- Holds the LED CPU core via cpuHold while a load session is active.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate; BIT_CYC = CLK_FREQ/BAUD (integer divide, must be >= 4).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- rx  in  1  asynchronous UART receive line; idle high.
- addrWr  out  8  RAM write address.
- dataWr  out  16  RAM write data.
- wrEn  out  1  RAM write strobe; one-cycle pulse.
- cpuHold  out  1  high while a load session is in progress; the core is held while high.
- loadDone  out  1  one-cycle pulse after the last word of a session is written.
- frameErr  out  1  sticky framing-error flag; cleared only by reset.

Behaviour:
- Reset (rst=0 at a clk edge): addrWr=0, dataWr=0, wrEn=0, cpuHold=0, loadDone=0, frameErr=0. RX synchronizer flops=1, all counters=0, both FSMs in IDLE/WAIT_CNT. Reset mid-byte or mid-session abandons everything; no partial write is issued.
- Input sync: rx passes through a 2-flop synchronizer; rxS is the second flop. All decisions use rxS.
- Byte receiver FSM:
  - IDLE: rxS falling edge (previous 1, current 0) -> START, bit counter cleared.
  - START: after BIT_CYC/2 cycles, sample rxS. If 0 -> DATA; if 1 (glitch) -> IDLE, no error.
  - DATA: sample every BIT_CYC cycles; 8 samples, LSB first -> STOP.
  - STOP: sample after BIT_CYC cycles. If 1 -> byteValid pulses one cycle, then IDLE. If 0 -> frameErr set, session aborted, then IDLE.
- Session FSM, advanced only on byteValid:
  - WAIT_CNT: byte = word count N (0 encodes 256). cpuHold rises the cycle after byteValid; addrWr=0, remaining=N -> HI.
  - HI: byte latched into dataWr[15:8] -> LO.
  - LO: byte latched into dataWr[7:0]. wrEn=1 for exactly the next cycle, with the current addrWr and the full dataWr. Cycle after wrEn: addrWr+1 (8-bit wrap), remaining-1.
  - After the write: if remaining reaches 0 -> loadDone pulses coincident with cpuHold falling, then WAIT_CNT; else -> HI.
- Abort on framing error in any session state: cpuHold=0 next cycle, return to WAIT_CNT, no wrEn, no loadDone. Words already written stay in RAM; addrWr holds its value until the next count byte resets it to 0.
- N=256: addrWr wraps 255->0 only after the final write; every address is written exactly once.
- dataWr and addrWr are stable whenever wrEn=1. Between writes they hold their last value.
- Throughput: at most one byte per 10*BIT_CYC cycles. The session FSM is always ready, so bytes are never dropped.

Test Plan:
- Sim params CLK_FREQ=1600, BAUD=100 (BIT_CYC=16). Hold rst=0 for 3 cycles -> all outputs 0, cpuHold=0; rx idle.
- Send bytes 0x02,0xA5,0x3C,0x12,0x34 -> wrEn pulses twice: (addr 0, 0xA53C), then (addr 1, 0x1234). loadDone pulses once with cpuHold falling. cpuHold=1 from after the 0x02 byte until loadDone.
- Send 0x01, then 0xFF with the stop bit driven 0 -> frameErr=1, cpuHold=0, no wrEn. Then send 0x01,0xBE,0xEF -> write (addr 0, 0xBEEF); frameErr stays 1.
- Drive a 4-cycle low glitch on idle rx -> no byte decoded, no error, all outputs unchanged.
- Send count 0x00, then 512 bytes -> 256 writes covering addr 0..255 in order; addrWr=0 after the final write; one loadDone.
- Assert rst=0 after the high byte of word 1 in a 3-word session -> no wrEn, cpuHold=0. A new session after reset writes from addr 0.
